// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// alu_issue_ctrl: valid/ready front end that decodes MIPS ops, drives the ALU,
// waits a settle time and returns captured result/flags.   Rev 1.0
// ============================================================================
`default_nettype none

module alu_issue_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_opcode,
  input  logic [5:0]       req_funct,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [2:0]       alu_cmd,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_result,
  input  logic             alu_cout,
  input  logic             alu_flag,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_cout,
  output logic             rsp_flag,
  output logic             rsp_zero,
  output logic             rsp_illegal,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] c_settle_load = 4'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        w_legal;
  logic [2:0]  w_cmd;
  logic        w_accept;
  logic        w_capture;
  logic        w_handshake;

  always_comb begin
    w_legal = 1'b1;
    w_cmd   = 3'b000;
    if (req_opcode == 6'b000000) begin
      case (req_funct)
        6'b100000: w_cmd = 3'b000;
        6'b100010: w_cmd = 3'b001;
        6'b100110: w_cmd = 3'b010;
        6'b101010: w_cmd = 3'b011;
        6'b100100: w_cmd = 3'b100;
        6'b101111: w_cmd = 3'b101;
        6'b100111: w_cmd = 3'b110;
        6'b100101: w_cmd = 3'b111;
        default:   w_legal = 1'b0;
      endcase
    end else begin
      case (req_opcode)
        6'b001000: w_cmd = 3'b000;
        6'b001110: w_cmd = 3'b010;
        6'b001010: w_cmd = 3'b011;
        6'b001100: w_cmd = 3'b100;
        6'b001101: w_cmd = 3'b111;
        default:   w_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_legal ? SETTLE : RESP;
      end
      SETTLE: begin
        if (r_cnt == 4'd0) w_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept    = req_valid && req_ready;
  assign w_capture   = (r_state == SETTLE) && (r_cnt == 4'd0);
  assign w_handshake = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Datapath: ALU operand registers, settle counter, response capture, counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_cmd     <= 3'b000;
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      r_cnt       <= 4'd0;
      rsp_result  <= 32'd0;
      rsp_cout    <= 1'b0;
      rsp_flag    <= 1'b0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
      op_count    <= '0;
    end else begin
      if (w_accept) begin
        if (w_legal) begin
          alu_cmd <= w_cmd;
          alu_a   <= req_a;
          alu_b   <= req_b;
          r_cnt   <= c_settle_load;
        end else begin
          rsp_result  <= 32'd0;
          rsp_cout    <= 1'b0;
          rsp_flag    <= 1'b0;
          rsp_zero    <= 1'b0;
          rsp_illegal <= 1'b1;
        end
      end
      if (r_state == SETTLE) begin
        if (w_capture) begin
          rsp_result  <= alu_result;
          rsp_cout    <= alu_cout;
          rsp_flag    <= alu_flag;
          rsp_zero    <= alu_zero;
          rsp_illegal <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
      if (w_handshake) op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// tb_alu_issue_ctrl: scoreboard bench with a behavioural ALU; a second
// instance with SETTLE_CYCLES=3 covers long settle and mid-op reset.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        flag;
    logic        zero;
    logic        ill;
    logic [2:0]  cmd;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  exp_t sb[$];

  // Main instance, SETTLE_CYCLES = 1
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [5:0]  req_opcode = '0, req_funct = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [2:0]  alu_cmd;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_cout, alu_flag, alu_zero;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic        rsp_cout, rsp_flag, rsp_zero, rsp_illegal;
  logic [15:0] op_count;

  // Second instance, SETTLE_CYCLES = 3
  logic        rst3 = 1'b1;
  logic        req_valid3 = 1'b0, req_ready3;
  logic [5:0]  req_opcode3 = '0, req_funct3 = '0;
  logic [31:0] req_a3 = '0, req_b3 = '0;
  logic [2:0]  alu_cmd3;
  logic [31:0] alu_a3, alu_b3, alu_result3;
  logic        alu_cout3, alu_flag3, alu_zero3;
  logic        rsp_valid3, rsp_ready3 = 1'b1;
  logic [31:0] rsp_result3;
  logic        rsp_cout3, rsp_flag3, rsp_zero3, rsp_illegal3;
  logic [15:0] op_count3;

  // Returns {zero, flag, cout, result}
  function automatic logic [34:0] alu_f(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic co, fl;
    co = 1'b0; fl = 1'b0; r = 32'd0;
    case (c)
      3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; co = s[32];
                    fl = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b001: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; co = s[32];
                    fl = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b010: r = a ^ b;
      3'b011: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b100: r = a & b;
      3'b101: r = ~(a & b);
      3'b110: r = ~(a | b);
      default: r = a | b;
    endcase
    return {(r == 32'd0), fl, co, r};
  endfunction

  assign {alu_zero, alu_flag, alu_cout, alu_result}     = alu_f(alu_cmd, alu_a, alu_b);
  assign {alu_zero3, alu_flag3, alu_cout3, alu_result3} = alu_f(alu_cmd3, alu_a3, alu_b3);

  alu_issue_ctrl #(.SETTLE_CYCLES(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
    .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .alu_cout(alu_cout), .alu_flag(alu_flag), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_flag(rsp_flag), .rsp_zero(rsp_zero),
    .rsp_illegal(rsp_illegal), .op_count(op_count)
  );

  alu_issue_ctrl #(.SETTLE_CYCLES(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_opcode(req_opcode3), .req_funct(req_funct3), .req_a(req_a3), .req_b(req_b3),
    .alu_cmd(alu_cmd3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_result(alu_result3),
    .alu_cout(alu_cout3), .alu_flag(alu_flag3), .alu_zero(alu_zero3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
    .rsp_cout(rsp_cout3), .rsp_flag(rsp_flag3), .rsp_zero(rsp_zero3),
    .rsp_illegal(rsp_illegal3), .op_count(op_count3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake of the main DUT.
  exp_t m_e;
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_rsp", 64'd1, 64'd0);
      end else begin
        m_e = sb.pop_front();
        chk({m_e.name, "_result"}, {32'd0, rsp_result}, {32'd0, m_e.res});
        chk({m_e.name, "_cout_flag_zero_ill_cmd"},
            {57'd0, rsp_cout, rsp_flag, rsp_zero, rsp_illegal, alu_cmd},
            {57'd0, m_e.cout, m_e.flag, m_e.zero, m_e.ill, m_e.cmd});
      end
    end
  end

  task automatic send(input string name, input logic [5:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic ec, input logic ef,
                      input logic ez, input logic ei, input logic [2:0] ecmd, input int elat);
    exp_t x;
    int n;
    x.res = er; x.cout = ec; x.flag = ef; x.zero = ez; x.ill = ei; x.cmd = ecmd; x.name = name;
    sb.push_back(x);
    @(negedge clk);
    req_opcode = op; req_funct = fn; req_a = a; req_b = b; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk({name, "_accept_timeout"}, 64'(n >= 50), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk({name, "_latency"}, 64'(n), 64'(elat));
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    exp_cnt++;
    chk({name, "_op_count"}, {48'd0, op_count}, 64'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    rst3  = 1'b0;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_alu_bus", {29'd0, alu_cmd, alu_a}, 64'd0);
    chk("rst_alu_b", {32'd0, alu_b}, 64'd0);
    chk("rst_rsp", {28'd0, rsp_result, rsp_cout, rsp_flag, rsp_zero, rsp_illegal}, 64'd0);
    chk("rst_op_count", {48'd0, op_count}, 64'd0);

    //    name         op         funct      a             b             result        c  f  z  i  cmd   lat
    send("add_ovf",   6'b000000, 6'b100000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0, 0, 3'b000, 1);
    send("sub_eq",    6'b000000, 6'b100010, 32'h12345678, 32'h12345678, 32'h00000000, 1, 0, 1, 0, 3'b001, 1);
    send("slti",      6'b001010, 6'b000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 0, 3'b011, 1);
    send("nand",      6'b000000, 6'b101111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 0, 1, 0, 3'b101, 1);
    send("ill_rtype", 6'b000000, 6'b000111, 32'h11111111, 32'h22222222, 32'h00000000, 0, 0, 0, 1, 3'b101, 0);
    send("addi_cry",  6'b001000, 6'b111111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1, 0, 3'b000, 1);
    send("ori",       6'b001101, 6'b000000, 32'hF0F00000, 32'h0000FFFF, 32'hF0F0FFFF, 0, 0, 0, 0, 3'b111, 1);
    send("xor",       6'b000000, 6'b100110, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 0, 0, 0, 0, 3'b010, 1);
    send("andi",      6'b001100, 6'b000000, 32'h12345678, 32'h0000FFFF, 32'h00005678, 0, 0, 0, 0, 3'b100, 1);
    send("nor",       6'b000000, 6'b100111, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 0, 3'b110, 1);
    send("ill_itype", 6'b000010, 6'b100000, 32'h00000005, 32'h00000006, 32'h00000000, 0, 0, 0, 1, 3'b110, 0);
    send("slt_r",     6'b000000, 6'b101010, 32'h00000005, 32'h80000000, 32'h00000000, 0, 0, 1, 0, 3'b011, 1);

    // Backpressure: first op waits in RESP while a second request is pending.
    begin
      exp_t x;
      @(negedge clk);
      rsp_ready = 1'b0;
      x.res = 32'd3; x.cout = 0; x.flag = 0; x.zero = 0; x.ill = 0; x.cmd = 3'b000; x.name = "bp_first";
      sb.push_back(x);
      req_opcode = 6'b000000; req_funct = 6'b100000; req_a = 32'd1; req_b = 32'd2; req_valid = 1'b1;
      @(posedge clk); #1;
      x.res = 32'hFFFFFFFE; x.cout = 0; x.flag = 0; x.zero = 0; x.ill = 0; x.cmd = 3'b001; x.name = "bp_second";
      sb.push_back(x);
      req_funct = 6'b100010; req_a = 32'd5; req_b = 32'd7;
      n = 0;
      while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("bp_first_latency", 64'(n), 64'd1);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("bp_hold_result", {32'd0, rsp_result}, 64'd3);
        chk("bp_hold_req_ready", 64'(req_ready), 64'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_no_accept_on_handshake", {62'd0, req_ready, rsp_valid}, 64'd2);
      @(posedge clk); #1;
      chk("bp_second_accepted", 64'(req_ready), 64'd0);
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp_second_rsp_valid", 64'(rsp_valid), 64'd1);
      @(posedge clk); #1;
      exp_cnt += 2;
      chk("bp_op_count", {48'd0, op_count}, 64'(exp_cnt));
      chk("bp_sb_drained", 64'(sb.size()), 64'd0);
    end

    // Long settle on the second instance, then reset in the middle of SETTLE.
    @(negedge clk);
    req_opcode3 = 6'b000000; req_funct3 = 6'b100000; req_a3 = 32'd1; req_b3 = 32'd1; req_valid3 = 1'b1;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    n = 0;
    while (!rsp_valid3 && n < 50) begin @(posedge clk); #1; n++; end
    chk("s3_latency", 64'(n), 64'd3);
    chk("s3_result", {32'd0, rsp_result3}, 64'd2);
    @(posedge clk); #1;
    chk("s3_op_count", {48'd0, op_count3}, 64'd1);
    @(negedge clk);
    req_opcode3 = 6'b000000; req_funct3 = 6'b100010; req_a3 = 32'h55; req_b3 = 32'h11; req_valid3 = 1'b1;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    @(posedge clk); #1;
    chk("s3_in_settle", {29'd0, alu_cmd3, alu_a3}, {29'd0, 3'b001, 32'h55});
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("s3rst_rsp_valid", 64'(rsp_valid3), 64'd0);
      chk("s3rst_alu_bus", {29'd0, alu_cmd3, alu_a3 | alu_b3}, 64'd0);
      chk("s3rst_op_count", {48'd0, op_count3}, 64'd0);
      chk("s3rst_req_ready", 64'(req_ready3), 64'd1);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Front-end initiator for the 32-bit ALU. It accepts MIPS-style operations over a valid/ready request channel and decodes opcode/funct into the 3-bit ALU command. It drives the ALU command and operands from registers, waits a programmable settle time, then captures result, carry-out, overflow flag and zero flag. The captured values are returned on a valid/ready response channel. One operation is in flight at a time; there is no buffering beyond the response register.

Parameters:
SETTLE_CYCLES, 1, cycles the ALU inputs are held stable before capture (legal range 1..15)
CNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_opcode  in  6  MIPS opcode field
req_funct  in  6  MIPS funct field (used only when opcode=000000)
req_a  in  32  operand A
req_b  in  32  operand B (immediates already extended by the requester)
alu_cmd  out  3  command to ALU
alu_a  out  32  operand A to ALU
alu_b  out  32  operand B to ALU
alu_result  in  32  ALU result
alu_cout  in  1  ALU carry-out
alu_flag  in  1  ALU overflow flag
alu_zero  in  1  ALU zero flag
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  32  captured result
rsp_cout  out  1  captured carry-out
rsp_flag  out  1  captured overflow flag
rsp_zero  out  1  captured zero flag
rsp_illegal  out  1  request did not decode to a legal operation
op_count  out  CNT_W  number of completed response handshakes

Behaviour:
- Reset (synchronous, active-high, wins over all other events):
  - State goes to IDLE.
  - alu_cmd, alu_a, alu_b = 0.
  - rsp_* = 0, rsp_valid = 0, op_count = 0.
  - req_ready = 1 in the cycle after reset deasserts.
- Decode, R-type (opcode 000000) by funct:
  - 100000 add -> 000
  - 100010 sub -> 001
  - 100110 xor -> 010
  - 101010 slt -> 011
  - 100100 and -> 100
  - 101111 nand (team custom) -> 101
  - 100111 nor -> 110
  - 100101 or -> 111
- Decode, I-type by opcode:
  - 001000 addi -> 000
  - 001110 xori -> 010
  - 001010 slti -> 011
  - 001100 andi -> 100
  - 001101 ori -> 111
- Any other opcode/funct combination is illegal.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - req_ready = 1, rsp_valid = 0.
  - Accept on an edge where req_valid && req_ready.
  - Legal request: alu_cmd/alu_a/alu_b are loaded at that edge, the settle counter loads SETTLE_CYCLES-1, and the FSM goes to SETTLE.
  - Illegal request: alu_* are unchanged. rsp_result = 0, rsp_cout = 0, rsp_flag = 0, rsp_zero = 0, rsp_illegal = 1 are loaded, and the FSM goes to RESP. rsp_valid is high the cycle after acceptance.
- SETTLE:
  - req_ready = 0, alu_* held stable.
  - The counter decrements each edge.
  - On the edge where the counter = 0: capture alu_result/cout/flag/zero into rsp_*, set rsp_illegal = 0, go to RESP.
  - Latency for a legal request: rsp_valid rises SETTLE_CYCLES edges after the accepting edge.
- RESP:
  - rsp_valid = 1, req_ready = 0.
  - rsp_* are stable until handshake; req_valid is ignored.
  - On rsp_valid && rsp_ready: op_count increments (wraps modulo 2^CNT_W, illegal responses included) and the FSM goes to IDLE.
  - Throughput limit: no request is accepted on the handshake edge; earliest next accept is the following edge.
- alu_cmd/alu_a/alu_b are registered outputs and hold their last values in IDLE and RESP.
- rsp_cout and rsp_flag are passed through exactly as the ALU reports them (the ALU zeroes them for non-add/sub operations). No re-masking is done.
- rsp_zero comes from alu_zero, not recomputed.
- Reset mid-SETTLE or mid-RESP: the operation is dropped, no response is produced, and op_count = 0.

Test Plan:
- add funct 100000, a=0x7FFFFFFF, b=0x00000001, SETTLE_CYCLES=1, rsp_ready=1 -> alu_cmd=000; rsp_result=0x80000000, rsp_flag=1, rsp_cout=0, rsp_zero=0; rsp_valid 1 edge after accept; op_count=1.
- sub funct 100010, a=b=0x12345678 -> alu_cmd=001; rsp_result=0, rsp_zero=1, rsp_cout=1, rsp_flag=0.
- slti opcode 001010, a=0xFFFFFFFF, b=0x00000001 -> alu_cmd=011, rsp_result=0x00000001; nand funct 101111, a=b=0xFFFFFFFF -> alu_cmd=101, rsp_result=0, rsp_zero=1.
- Illegal opcode 000000 funct 000111 -> rsp_illegal=1, rsp_result=0, alu_cmd unchanged from previous op; rsp_valid 1 edge after accept; op_count increments.
- Backpressure: rsp_ready=0 for 5 cycles while req_valid=1 with a new op -> rsp_* stable, req_ready=0, second op not accepted; after handshake, second op accepted one edge later.
- SETTLE_CYCLES=3: reset asserted on the second SETTLE cycle -> rsp_valid never rises, alu_*=0, op_count=0, req_ready=1 after reset deasserts.
